// File: rtl/bcd_counter_seg_mux.sv
// N-digit BCD up/down counter with parallel load, wrap flag and a
// time-multiplexed 7-segment display driver. Single clock domain; the count
// and scan rates come from clock-enable ticks, not derived clocks.

// One BCD digit's next value when it is told to step up or down.
module bcd_digit_step (
   input  logic [3:0] dig_i,
   input  logic       step_i,
   input  logic       up_i,
   output logic [3:0] dig_o
);
   // Wrap 9->0 going up and 0->9 going down; hold when not stepping.
   always_comb begin
      dig_o = dig_i;
      if (step_i) begin
         if (up_i) dig_o = (dig_i >= 4'd9) ? 4'd0 : dig_i + 4'd1;
         else      dig_o = (dig_i == 4'd0) ? 4'd9 : dig_i - 4'd1;
      end
   end
endmodule

module bcd_counter_seg_mux #(
   parameter int DIGITS    = 4,
   parameter int COUNT_DIV = 1000000,
   parameter int SCAN_DIV  = 10000
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  EN,
   input  logic                  UP_DN,
   input  logic                  LOAD,
   input  logic [4*DIGITS-1:0]   LOAD_VAL,
   input  logic                  BLANK_LZ,
   output logic [4*DIGITS-1:0]   COUNT,
   output logic                  WRAP,
   output logic [6:0]            SEG_C,
   output logic [DIGITS-1:0]     SEG_SEL
);
   localparam int CPW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam int SPW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW  = $clog2(DIGITS);
   localparam logic [CPW-1:0] CNT_LAST  = CPW'(COUNT_DIV - 1);
   localparam logic [SPW-1:0] SCAN_LAST = SPW'(SCAN_DIV - 1);
   localparam logic [IW-1:0]  IDX_LAST  = IW'(DIGITS - 1);

   logic [DIGITS-1:0][3:0] count_q, count_d, count_step, load_clean;
   logic                   wrap_q, wrap_d;
   logic [CPW-1:0]         cnt_pre_q, cnt_pre_d;
   logic [SPW-1:0]         scan_pre_q, scan_pre_d;
   logic [IW-1:0]          scan_idx_q, scan_idx_d;
   logic [6:0]             seg_c_q, seg_c_d;
   logic [DIGITS-1:0]      seg_sel_q, seg_sel_d;

   logic [DIGITS:0]        all9_below, all0_below, zero_from;
   logic [DIGITS-1:0]      step_en;
   logic                   tick;
   logic [3:0]             cur_digit;
   logic                   blank;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0: return 7'h3f;
         4'd1: return 7'h06;
         4'd2: return 7'h5b;
         4'd3: return 7'h4f;
         4'd4: return 7'h66;
         4'd5: return 7'h6d;
         4'd6: return 7'h7d;
         4'd7: return 7'h07;
         4'd8: return 7'h7f;
         4'd9: return 7'h6f;
         default: return 7'h00;
      endcase
   endfunction

   // Ripple conditions: a digit steps only when every lower digit is at its
   // rollover value; zero_from[k] says digits k..DIGITS-1 are all zero.
   assign all9_below[0]     = 1'b1;
   assign all0_below[0]     = 1'b1;
   assign zero_from[DIGITS] = 1'b1;

   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      assign all9_below[g+1] = all9_below[g] & (count_q[g] == 4'd9);
      assign all0_below[g+1] = all0_below[g] & (count_q[g] == 4'd0);
      assign zero_from[g]    = zero_from[g+1] & (count_q[g] == 4'd0);
      assign step_en[g]      = UP_DN ? all9_below[g] : all0_below[g];
      assign load_clean[g]   = (LOAD_VAL[4*g +: 4] > 4'd9) ? 4'd0 : LOAD_VAL[4*g +: 4];

      bcd_digit_step u_step (
         .dig_i  (count_q[g]),
         .step_i (step_en[g]),
         .up_i   (UP_DN),
         .dig_o  (count_step[g])
      );
   end

   assign tick = EN && (cnt_pre_q == CNT_LAST);

   // Count prescaler, load and tick-driven count update; load beats a tick.
   always_comb begin
      count_d   = count_q;
      cnt_pre_d = cnt_pre_q;
      wrap_d    = 1'b0;
      if (LOAD) begin
         count_d   = load_clean;
         cnt_pre_d = '0;
      end else if (EN) begin
         if (tick) begin
            cnt_pre_d = '0;
            count_d   = count_step;
            wrap_d    = UP_DN ? all9_below[DIGITS] : all0_below[DIGITS];
         end else begin
            cnt_pre_d = cnt_pre_q + CPW'(1);
         end
      end
   end

   // Free-running scan prescaler and digit index, unaffected by EN and LOAD.
   always_comb begin
      scan_pre_d = scan_pre_q + SPW'(1);
      scan_idx_d = scan_idx_q;
      if (scan_pre_q == SCAN_LAST) begin
         scan_pre_d = '0;
         scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IW'(1);
      end
   end

   // Select and segments are built from the same index and count so the
   // registered pair never disagrees.
   always_comb begin
      cur_digit = count_q[scan_idx_q];
      blank     = BLANK_LZ && (scan_idx_q != '0) && zero_from[scan_idx_q];
      seg_sel_d = ~(DIGITS'(1) << scan_idx_q);
      seg_c_d   = blank ? 7'h00 : seg_decode(cur_digit);
   end

   // State registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         count_q    <= '0;
         wrap_q     <= 1'b0;
         cnt_pre_q  <= '0;
         scan_pre_q <= '0;
         scan_idx_q <= '0;
         seg_sel_q  <= ~DIGITS'(1);
         seg_c_q    <= 7'h3f;
      end else begin
         count_q    <= count_d;
         wrap_q     <= wrap_d;
         cnt_pre_q  <= cnt_pre_d;
         scan_pre_q <= scan_pre_d;
         scan_idx_q <= scan_idx_d;
         seg_sel_q  <= seg_sel_d;
         seg_c_q    <= seg_c_d;
      end
   end

   assign COUNT   = count_q;
   assign WRAP    = wrap_q;
   assign SEG_C   = seg_c_q;
   assign SEG_SEL = seg_sel_q;

endmodule

// File: tb/tb_bcd_counter_seg_mux.sv
// Directed bench for bcd_counter_seg_mux with DIGITS=3, COUNT_DIV=4, SCAN_DIV=2.
module tb_bcd_counter_seg_mux;
   logic        CLK = 1'b0;
   logic        RESET, EN, UP_DN, LOAD, BLANK_LZ;
   logic [11:0] LOAD_VAL;
   logic [11:0] COUNT;
   logic        WRAP;
   logic [6:0]  SEG_C;
   logic [2:0]  SEG_SEL;

   int pass_cnt = 0;
   int total_cnt = 0;
   int n_cyc = 0;

   bcd_counter_seg_mux #(.DIGITS(3), .COUNT_DIV(4), .SCAN_DIV(2)) dut (
      .CLK(CLK), .RESET(RESET), .EN(EN), .UP_DN(UP_DN), .LOAD(LOAD),
      .LOAD_VAL(LOAD_VAL), .BLANK_LZ(BLANK_LZ), .COUNT(COUNT), .WRAP(WRAP),
      .SEG_C(SEG_C), .SEG_SEL(SEG_SEL)
   );

   always #5 CLK = ~CLK;

   // Edges since the last reset edge; the scan pattern is a function of it.
   always @(posedge CLK) begin
      if (RESET) n_cyc <= 0;
      else       n_cyc <= n_cyc + 1;
   end

   typedef struct {
      logic [11:0] load_val;
      logic        up;
      int          ticks;
      logic [11:0] exp_count;
      int          exp_wraps;
   } vec_t;

   vec_t vecs[9];

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Displayed digit index after edge n: index advances every 2 edges and
   // the display lags the index by one edge.
   function automatic int disp_idx(input int n);
      return (n == 0) ? 0 : ((n - 1) / 2) % 3;
   endfunction

   function automatic logic [2:0] exp_sel(input int n);
      logic [2:0] t;
      t = 3'b001 << disp_idx(n);
      return ~t;
   endfunction

   task automatic blank_case(input string nm, input logic [11:0] v, input logic bl,
                             input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2);
      logic [6:0] e;
      int k;
      LOAD = 1'b1; LOAD_VAL = v; BLANK_LZ = bl;
      step();
      LOAD = 1'b0;
      step();
      for (int i = 0; i < 6; i++) begin
         step();
         k = disp_idx(n_cyc);
         e = (k == 0) ? e0 : (k == 1) ? e1 : e2;
         chk(nm, {25'd0, SEG_C}, {25'd0, e});
      end
   endtask

   initial begin
      int wraps;

      vecs[0] = '{12'h999, 1'b1, 1, 12'h000, 1};
      vecs[1] = '{12'h199, 1'b1, 1, 12'h200, 0};
      vecs[2] = '{12'h100, 1'b0, 1, 12'h099, 0};
      vecs[3] = '{12'h000, 1'b0, 1, 12'h999, 1};
      vecs[4] = '{12'h5a3, 1'b1, 0, 12'h503, 0};
      vecs[5] = '{12'h998, 1'b1, 3, 12'h001, 1};
      vecs[6] = '{12'h010, 1'b0, 2, 12'h008, 0};
      vecs[7] = '{12'hfff, 1'b1, 0, 12'h000, 0};
      vecs[8] = '{12'h909, 1'b1, 1, 12'h910, 0};

      RESET = 1'b1; EN = 1'b0; UP_DN = 1'b1; LOAD = 1'b0; BLANK_LZ = 1'b0; LOAD_VAL = '0;
      step();
      step();
      chk("rst_count", {20'd0, COUNT}, 32'h0);
      chk("rst_wrap", {31'd0, WRAP}, 32'h0);
      chk("rst_sel", {29'd0, SEG_SEL}, 32'h6);
      chk("rst_seg", {25'd0, SEG_C}, 32'h3f);

      // Free up-count from reset: 40 edges = 10 ticks; scan pattern each edge.
      RESET = 1'b0; EN = 1'b1; UP_DN = 1'b1;
      wraps = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (WRAP) wraps++;
         chk("scan_sel", {29'd0, SEG_SEL}, {29'd0, exp_sel(n_cyc)});
      end
      chk("upcnt_count", {20'd0, COUNT}, 32'h010);
      chk("upcnt_wrap", wraps, 0);

      // Load/tick vector table.
      for (int v = 0; v < 9; v++) begin
         LOAD = 1'b1; LOAD_VAL = vecs[v].load_val; UP_DN = vecs[v].up; EN = 1'b1;
         step();
         LOAD = 1'b0;
         wraps = 0;
         for (int c = 0; c < 4 * vecs[v].ticks; c++) begin
            step();
            if (WRAP) wraps++;
         end
         chk($sformatf("vec%0d_count", v), {20'd0, COUNT}, {20'd0, vecs[v].exp_count});
         chk($sformatf("vec%0d_wraps", v), wraps, vecs[v].exp_wraps);
      end

      // LOAD in the very cycle a wrapping tick is due.
      LOAD = 1'b1; LOAD_VAL = 12'h999; UP_DN = 1'b1; EN = 1'b1;
      step();
      LOAD = 1'b0;
      step(); step(); step();
      LOAD = 1'b1; LOAD_VAL = 12'h5a3;
      step();
      LOAD = 1'b0;
      chk("prio_count", {20'd0, COUNT}, 32'h503);
      chk("prio_wrap", {31'd0, WRAP}, 32'h0);
      step(); step(); step();
      chk("prio_pre_hold", {20'd0, COUNT}, 32'h503);
      step();
      chk("prio_pre_tick", {20'd0, COUNT}, 32'h504);

      // Freeze: count holds while scanning continues; toggle UP_DN meanwhile.
      EN = 1'b0;
      for (int i = 0; i < 20; i++) begin
         UP_DN = i[0];
         step();
         chk("frz_sel", {29'd0, SEG_SEL}, {29'd0, exp_sel(n_cyc)});
      end
      chk("frz_count", {20'd0, COUNT}, 32'h504);

      // Leading-zero blanking.
      blank_case("blank_007_on",  12'h007, 1'b1, 7'h07, 7'h00, 7'h00);
      blank_case("blank_007_off", 12'h007, 1'b0, 7'h07, 7'h3f, 7'h3f);
      blank_case("blank_000_on",  12'h000, 1'b1, 7'h3f, 7'h00, 7'h00);
      blank_case("blank_050_on",  12'h050, 1'b1, 7'h3f, 7'h6d, 7'h00);
      blank_case("blank_305_on",  12'h305, 1'b1, 7'h6d, 7'h3f, 7'h4f);

      // Reset together with LOAD and a count enable.
      EN = 1'b1; LOAD = 1'b1; LOAD_VAL = 12'h555; RESET = 1'b1;
      step();
      chk("rstld_count", {20'd0, COUNT}, 32'h0);
      chk("rstld_sel", {29'd0, SEG_SEL}, 32'h6);
      chk("rstld_seg", {25'd0, SEG_C}, 32'h3f);
      chk("rstld_wrap", {31'd0, WRAP}, 32'h0);
      RESET = 1'b0; LOAD = 1'b0;
      step();
      chk("rstld_after", {20'd0, COUNT}, 32'h0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
